// File: rtl/nasti_dma_pkg.sv
// Shared types and helpers for the NASTI DMA data mover.
//   state_t     : mover FSM states
//   BURST_INCR  : AXI INCR burst encoding
//   RESP_OKAY   : AXI OKAY response encoding
//   BOUNDARY_4K : bursts may not cross this address boundary
//   calc_burst  : beats for the next burst (remaining, MAX_BURST and 4 KiB limits)
package nasti_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR,
    WR_DATA,
    WR_RESP,
    FINISH
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam int unsigned BOUNDARY_4K = 4096;

  // Smallest of: remaining beats, max_burst, beats left before the next
  // 4 KiB boundary of src, and the same for dst. Addresses are beat aligned,
  // so the room to a boundary is always at least one beat.
  function automatic logic [8:0] calc_burst(
    input logic [63:0] remaining,
    input logic [63:0] src,
    input logic [63:0] dst,
    input int unsigned size_log2,
    input int unsigned max_burst
  );
    logic [63:0] beats;
    logic [63:0] src_room;
    logic [63:0] dst_room;
    beats    = remaining;
    src_room = (64'(BOUNDARY_4K) - (src & 64'(BOUNDARY_4K - 1))) >> size_log2;
    dst_room = (64'(BOUNDARY_4K) - (dst & 64'(BOUNDARY_4K - 1))) >> size_log2;
    if (beats > 64'(max_burst)) beats = 64'(max_burst);
    if (beats > src_room) beats = src_room;
    if (beats > dst_room) beats = dst_room;
    return beats[8:0];
  endfunction

endpackage

// File: rtl/nasti_dma_buf.sv
// Burst staging buffer: DEPTH x DATA_WIDTH register file.
//   clk     : clock
//   we      : write enable
//   wr_idx  : write index
//   wr_data : write data
//   rd_idx  : read index (asynchronous read)
//   rd_data : read data
module nasti_dma_buf #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned IDX_W      = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_data;
  end

  always_comb begin
    rd_data = mem[rd_idx];
  end

endmodule

// File: rtl/nasti_dma_mover.sv
// NASTI (AXI4) memory-to-memory data mover: read burst into a buffer, then
// write the buffer out, repeating until the byte count is exhausted.
//   aclk, areset        : clock, asynchronous active-high reset
//   en                  : start request (level)
//   src_addr, dst_addr  : beat-aligned byte addresses
//   length              : byte count, multiple of the beat size
//   done                : 1 = idle/finished
//   err                 : sticky error from the last transfer
//   ar_* / r_*          : read address / read data channels
//   aw_* / w_* / b_*    : write address / write data / write response channels
module nasti_dma_mover
  import nasti_dma_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    en,
  input  logic [ADDR_WIDTH-1:0]   src_addr,
  input  logic [ADDR_WIDTH-1:0]   dst_addr,
  input  logic [ADDR_WIDTH-1:0]   length,
  output logic                    done,
  output logic                    err,
  output logic [ADDR_WIDTH-1:0]   ar_addr,
  output logic [7:0]              ar_len,
  output logic [2:0]              ar_size,
  output logic [1:0]              ar_burst,
  output logic                    ar_valid,
  input  logic                    ar_ready,
  input  logic [DATA_WIDTH-1:0]   r_data,
  input  logic [1:0]              r_resp,
  input  logic                    r_last,
  input  logic                    r_valid,
  output logic                    r_ready,
  output logic [ADDR_WIDTH-1:0]   aw_addr,
  output logic [7:0]              aw_len,
  output logic [2:0]              aw_size,
  output logic [1:0]              aw_burst,
  output logic                    aw_valid,
  input  logic                    aw_ready,
  output logic [DATA_WIDTH-1:0]   w_data,
  output logic [DATA_WIDTH/8-1:0] w_strb,
  output logic                    w_last,
  output logic                    w_valid,
  input  logic                    w_ready,
  input  logic [1:0]              b_resp,
  input  logic                    b_valid,
  output logic                    b_ready
);

  localparam int unsigned SIZE_LOG2 = $clog2(DATA_WIDTH / 8);
  localparam int unsigned IDX_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] src;
  logic [ADDR_WIDTH-1:0] dst;
  logic [ADDR_WIDTH-1:0] rem;
  logic [8:0]            burst;
  logic [7:0]            idx;

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] next_src;
  logic [ADDR_WIDTH-1:0] next_dst;
  logic [ADDR_WIDTH-1:0] next_rem;
  logic [ADDR_WIDTH-1:0] req_beats;
  logic [8:0]            first_burst;
  logic [8:0]            next_burst;
  logic                  beat_last;
  logic                  buf_we;

  always_comb begin
    step        = ADDR_WIDTH'(burst) << SIZE_LOG2;
    next_src    = src + step;
    next_dst    = dst + step;
    next_rem    = rem - ADDR_WIDTH'(burst);
    req_beats   = length >> SIZE_LOG2;
    first_burst = calc_burst(64'(req_beats), 64'(src_addr), 64'(dst_addr),
                             SIZE_LOG2, MAX_BURST);
    next_burst  = calc_burst(64'(next_rem), 64'(next_src), 64'(next_dst),
                             SIZE_LOG2, MAX_BURST);
    beat_last   = ({1'b0, idx} == burst - 9'd1);
    buf_we      = (state == RD_DATA) && r_valid && r_ready;
  end

  always_comb begin
    ar_size  = 3'(SIZE_LOG2);
    aw_size  = 3'(SIZE_LOG2);
    ar_burst = BURST_INCR;
    aw_burst = BURST_INCR;
    w_strb   = '1;
  end

  // idx is the read write-index in RD_DATA and the write read-index in WR_DATA.
  nasti_dma_buf #(
    .DEPTH      (MAX_BURST),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_buf (
    .clk     (aclk),
    .we      (buf_we),
    .wr_idx  (idx[IDX_W-1:0]),
    .wr_data (r_data),
    .rd_idx  (idx[IDX_W-1:0]),
    .rd_data (w_data)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state    <= IDLE;
      src      <= '0;
      dst      <= '0;
      rem      <= '0;
      burst    <= '0;
      idx      <= '0;
      done     <= 1'b1;
      err      <= 1'b0;
      ar_addr  <= '0;
      ar_len   <= '0;
      ar_valid <= 1'b0;
      r_ready  <= 1'b0;
      aw_addr  <= '0;
      aw_len   <= '0;
      aw_valid <= 1'b0;
      w_last   <= 1'b0;
      w_valid  <= 1'b0;
      b_ready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            src   <= src_addr;
            dst   <= dst_addr;
            rem   <= req_beats;
            burst <= first_burst;
            err   <= 1'b0;
            done  <= 1'b0;
            state <= (req_beats == '0) ? FINISH : RD_ADDR;
          end
        end

        // First cycle in the state raises ar_valid; the handshake is taken
        // only once ar_valid is already visible to the slave.
        RD_ADDR: begin
          if (!ar_valid) begin
            ar_valid <= 1'b1;
            ar_addr  <= src;
            ar_len   <= 8'(burst - 9'd1);
          end else if (ar_ready) begin
            ar_valid <= 1'b0;
            r_ready  <= 1'b1;
            idx      <= '0;
            state    <= RD_DATA;
          end
        end

        // Leave on r_last or on the expected beat count, whichever is first;
        // disagreement between the two is a protocol error.
        RD_DATA: begin
          if (r_valid) begin
            idx <= idx + 8'd1;
            if (r_resp != RESP_OKAY || r_last != beat_last) err <= 1'b1;
            if (r_last || beat_last) begin
              r_ready  <= 1'b0;
              aw_valid <= 1'b1;
              aw_addr  <= dst;
              aw_len   <= 8'(burst - 9'd1);
              state    <= WR_ADDR;
            end
          end
        end

        WR_ADDR: begin
          if (aw_ready) begin
            aw_valid <= 1'b0;
            w_valid  <= 1'b1;
            w_last   <= (burst == 9'd1);
            idx      <= '0;
            state    <= WR_DATA;
          end
        end

        WR_DATA: begin
          if (w_ready) begin
            if (w_last) begin
              w_valid <= 1'b0;
              w_last  <= 1'b0;
              b_ready <= 1'b1;
              state   <= WR_RESP;
            end else begin
              idx    <= idx + 8'd1;
              w_last <= ({1'b0, idx} + 9'd2 == burst);
            end
          end
        end

        WR_RESP: begin
          if (b_valid) begin
            b_ready <= 1'b0;
            src     <= next_src;
            dst     <= next_dst;
            rem     <= next_rem;
            if (b_resp != RESP_OKAY) err <= 1'b1;
            if (err || b_resp != RESP_OKAY || next_rem == '0) begin
              state <= FINISH;
            end else begin
              burst <= next_burst;
              state <= RD_ADDR;
            end
          end
        end

        FINISH: begin
          done  <= 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nasti_dma_mover.sv
// Directed bench for nasti_dma_mover with a behavioural NASTI slave memory.
module tb_nasti_dma_mover;

  logic        aclk = 1'b0;
  logic        areset;
  logic        en;
  logic [63:0] src_addr, dst_addr, length;
  logic        done, err;
  logic [63:0] ar_addr, aw_addr;
  logic [7:0]  ar_len, aw_len;
  logic [2:0]  ar_size, aw_size;
  logic [1:0]  ar_burst, aw_burst;
  logic        ar_valid, ar_ready, aw_valid, aw_ready;
  logic [63:0] r_data, w_data;
  logic [1:0]  r_resp, b_resp;
  logic        r_last, r_valid, r_ready;
  logic [7:0]  w_strb;
  logic        w_last, w_valid, w_ready;
  logic        b_valid, b_ready;

  always #5 aclk = ~aclk;

  nasti_dma_mover #(
    .ADDR_WIDTH (64),
    .DATA_WIDTH (64),
    .MAX_BURST  (16)
  ) dut (
    .aclk(aclk), .areset(areset), .en(en),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .done(done), .err(err),
    .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_valid(r_valid), .r_ready(r_ready),
    .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
    .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready)
  );

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  // Slave model state and logs
  logic [63:0] mem [logic [63:0]];
  bit          bp = 1'b0;
  int unsigned err_beat = 1000;
  int unsigned rd_beat_total = 0;
  int unsigned ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
  int unsigned order_err = 0, proto_err = 0, valid_seen = 0;
  logic [63:0] ar_log_addr [8];
  logic [63:0] aw_log_addr [8];
  logic [7:0]  ar_log_len [8];
  logic [7:0]  aw_log_len [8];

  function automatic logic [63:0] pat(input logic [63:0] a);
    return {~a[31:0], a[31:0] ^ 32'h5A5A_C3C3};
  endfunction

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : pat(a);
  endfunction

  function automatic int unsigned count_bad(input logic [63:0] s, input logic [63:0] d,
                                            input int unsigned beats);
    int unsigned bad = 0;
    for (int unsigned i = 0; i < beats; i++)
      if (mem_rd(d + 64'(i) * 64'd8) !== pat(s + 64'(i) * 64'd8)) bad++;
    return bad;
  endfunction

  // Slave: capture handshakes before the edge, act on them 1 time unit after it.
  initial begin : slave
    bit          f_ar, f_r, f_aw, f_w, f_b;
    logic [63:0] c_ar_addr, c_aw_addr, c_w_data;
    logic [7:0]  c_ar_len, c_aw_len;
    logic        c_w_last;
    bit          rd_active, wr_aw_ok, b_pending;
    logic [63:0] rd_addr, wr_addr;
    int unsigned rd_len, rd_i, wr_len, wr_j;
    rd_active = 0; wr_aw_ok = 0; b_pending = 0;
    rd_addr = '0; wr_addr = '0; rd_len = 0; rd_i = 0; wr_len = 0; wr_j = 0;
    ar_ready = 0; aw_ready = 0; w_ready = 0;
    r_valid = 0; r_data = '0; r_resp = '0; r_last = 0;
    b_valid = 0; b_resp = '0;
    forever begin
      @(negedge aclk);
      f_ar = ar_valid && ar_ready;  c_ar_addr = ar_addr;  c_ar_len = ar_len;
      f_aw = aw_valid && aw_ready;  c_aw_addr = aw_addr;  c_aw_len = aw_len;
      f_r  = r_valid && r_ready;
      f_w  = w_valid && w_ready;    c_w_data = w_data;    c_w_last = w_last;
      f_b  = b_valid && b_ready;
      if (f_ar && (ar_size !== 3'd3 || ar_burst !== 2'b01)) proto_err++;
      if (f_aw && (aw_size !== 3'd3 || aw_burst !== 2'b01)) proto_err++;
      if (f_w && w_strb !== 8'hFF) proto_err++;
      if (ar_valid || aw_valid) valid_seen++;
      @(posedge aclk);
      #1;
      if (areset) begin
        rd_active = 0; wr_aw_ok = 0; b_pending = 0;
        r_valid = 0; b_valid = 0; ar_ready = 0; aw_ready = 0; w_ready = 0;
      end else begin
        if (f_ar) begin
          if (ar_cnt < 8) begin ar_log_addr[ar_cnt] = c_ar_addr; ar_log_len[ar_cnt] = c_ar_len; end
          ar_cnt++;
          rd_active = 1; rd_addr = c_ar_addr; rd_len = {24'd0, c_ar_len}; rd_i = 0;
        end
        if (f_r) begin
          rd_i++; rd_beat_total++; r_valid = 0;
          if (rd_i > rd_len) rd_active = 0;
        end
        if (f_aw) begin
          if (aw_cnt < 8) begin aw_log_addr[aw_cnt] = c_aw_addr; aw_log_len[aw_cnt] = c_aw_len; end
          aw_cnt++;
          wr_aw_ok = 1; wr_addr = c_aw_addr; wr_len = {24'd0, c_aw_len}; wr_j = 0;
        end
        if (f_w) begin
          w_cnt++;
          if (!wr_aw_ok) order_err++;
          else begin
            mem[wr_addr + 64'(wr_j) * 64'd8] = c_w_data;
            if (c_w_last !== (wr_j == wr_len)) proto_err++;
            wr_j++;
            if (c_w_last) begin wr_aw_ok = 0; b_pending = 1; end
          end
        end
        if (f_b) b_valid = 0;
        ar_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        aw_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        w_ready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!r_valid && rd_active && (!bp || $urandom_range(0, 1) == 1)) begin
          r_valid = 1;
          r_data  = mem_rd(rd_addr + 64'(rd_i) * 64'd8);
          r_last  = (rd_i == rd_len);
          r_resp  = (rd_beat_total == err_beat) ? 2'b10 : 2'b00;
        end
        if (b_pending && !b_valid && (!bp || $urandom_range(0, 1) == 1)) begin
          b_valid = 1; b_resp = 2'b00; b_pending = 0;
        end
      end
    end
  end

  task automatic clear_logs();
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
    order_err = 0; proto_err = 0; valid_seen = 0; rd_beat_total = 0;
  endtask

  task automatic kick(input logic [63:0] s, input logic [63:0] d, input logic [63:0] l);
    @(posedge aclk); #1;
    src_addr = s; dst_addr = d; length = l; en = 1'b1;
    @(posedge aclk); #1;
    en = 1'b0;
  endtask

  task automatic wait_done(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge aclk); #1;
      if (done) begin timed_out = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    n_total++; if (done !== 1'b1) $display("FAIL reset_done: got %b want 1", done); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
    n_total++; if ({ar_valid, aw_valid, w_valid, r_ready, b_ready} !== 5'b0)
      $display("FAIL reset_handshakes: got %b want 00000", {ar_valid, aw_valid, w_valid, r_ready, b_ready});
    else n_pass++;
    n_total++; if (ar_addr !== 64'h0 || aw_len !== 8'h0)
      $display("FAIL reset_addr_len: got ar_addr=%h aw_len=%h want 0", ar_addr, aw_len);
    else n_pass++;
    @(negedge aclk); areset = 1'b0;
    @(posedge aclk); #1;
    n_total++; if (done !== 1'b1) $display("FAIL idle_done: got %b want 1", done); else n_pass++;
  endtask

  task automatic test_single();
    bit to;
    clear_logs(); bp = 0;
    kick(64'h1000, 64'h8000, 64'd64);
    n_total++; if (done !== 1'b0 || ar_valid !== 1'b0)
      $display("FAIL latency_1: got done=%b ar_valid=%b want 0 0", done, ar_valid);
    else n_pass++;
    @(posedge aclk); #1;
    n_total++; if (ar_valid !== 1'b1 || ar_addr !== 64'h1000 || ar_len !== 8'd7)
      $display("FAIL latency_2: got ar_valid=%b ar_addr=%h ar_len=%0d want 1 1000 7", ar_valid, ar_addr, ar_len);
    else n_pass++;
    wait_done(to);
    n_total++; if (to) $display("FAIL single_timeout: got no done want done"); else n_pass++;
    n_total++; if (ar_cnt !== 1 || aw_cnt !== 1)
      $display("FAIL single_counts: got ar=%0d aw=%0d want 1 1", ar_cnt, aw_cnt);
    else n_pass++;
    n_total++; if (aw_log_addr[0] !== 64'h8000 || aw_log_len[0] !== 8'd7)
      $display("FAIL single_aw: got %h/%0d want 8000/7", aw_log_addr[0], aw_log_len[0]);
    else n_pass++;
    n_total++; if (count_bad(64'h1000, 64'h8000, 8) !== 0)
      $display("FAIL single_data: got %0d bad beats want 0", count_bad(64'h1000, 64'h8000, 8));
    else n_pass++;
    n_total++; if (err !== 1'b0 || proto_err !== 0 || order_err !== 0)
      $display("FAIL single_err: got err=%b proto=%0d order=%0d want 0 0 0", err, proto_err, order_err);
    else n_pass++;
  endtask

  task automatic test_two_bursts();
    bit to;
    clear_logs(); bp = 0;
    kick(64'h1000, 64'h10000, 64'd256);
    wait_done(to);
    n_total++; if (to) $display("FAIL two_timeout: got no done want done"); else n_pass++;
    n_total++; if (ar_cnt !== 2 || aw_cnt !== 2)
      $display("FAIL two_counts: got ar=%0d aw=%0d want 2 2", ar_cnt, aw_cnt);
    else n_pass++;
    n_total++; if (ar_log_addr[0] !== 64'h1000 || ar_log_addr[1] !== 64'h1080 ||
                   ar_log_len[0] !== 8'd15 || ar_log_len[1] !== 8'd15)
      $display("FAIL two_ar: got %h/%0d %h/%0d want 1000/15 1080/15",
               ar_log_addr[0], ar_log_len[0], ar_log_addr[1], ar_log_len[1]);
    else n_pass++;
    n_total++; if (aw_log_addr[1] !== 64'h10080 || aw_log_len[1] !== 8'd15)
      $display("FAIL two_aw: got %h/%0d want 10080/15", aw_log_addr[1], aw_log_len[1]);
    else n_pass++;
    n_total++; if (count_bad(64'h1000, 64'h10000, 32) !== 0)
      $display("FAIL two_data: got %0d bad beats want 0", count_bad(64'h1000, 64'h10000, 32));
    else n_pass++;
  endtask

  task automatic test_4k_boundary();
    bit to;
    clear_logs(); bp = 0;
    kick(64'h0FF0, 64'h9000, 64'd64);
    wait_done(to);
    n_total++; if (to) $display("FAIL b4k_timeout: got no done want done"); else n_pass++;
    n_total++; if (ar_cnt !== 2 || ar_log_addr[0] !== 64'h0FF0 || ar_log_len[0] !== 8'd1 ||
                   ar_log_addr[1] !== 64'h1000 || ar_log_len[1] !== 8'd5)
      $display("FAIL b4k_ar: got n=%0d %h/%0d %h/%0d want 2 ff0/1 1000/5",
               ar_cnt, ar_log_addr[0], ar_log_len[0], ar_log_addr[1], ar_log_len[1]);
    else n_pass++;
    n_total++; if (aw_cnt !== 2 || aw_log_addr[0] !== 64'h9000 || aw_log_len[0] !== 8'd1 ||
                   aw_log_addr[1] !== 64'h9010 || aw_log_len[1] !== 8'd5)
      $display("FAIL b4k_aw: got n=%0d %h/%0d %h/%0d want 2 9000/1 9010/5",
               aw_cnt, aw_log_addr[0], aw_log_len[0], aw_log_addr[1], aw_log_len[1]);
    else n_pass++;
    n_total++; if (count_bad(64'h0FF0, 64'h9000, 8) !== 0)
      $display("FAIL b4k_data: got %0d bad beats want 0", count_bad(64'h0FF0, 64'h9000, 8));
    else n_pass++;
  endtask

  task automatic test_zero_length();
    clear_logs(); bp = 0;
    kick(64'h5000, 64'hD000, 64'd0);
    n_total++; if (done !== 1'b0) $display("FAIL zero_done_low: got %b want 0", done); else n_pass++;
    @(posedge aclk); #1;
    n_total++; if (done !== 1'b1) $display("FAIL zero_done_back: got %b want 1", done); else n_pass++;
    repeat (4) @(posedge aclk);
    #1;
    n_total++; if (valid_seen !== 0 || ar_cnt !== 0 || aw_cnt !== 0)
      $display("FAIL zero_no_valid: got seen=%0d ar=%0d aw=%0d want 0 0 0", valid_seen, ar_cnt, aw_cnt);
    else n_pass++;
  endtask

  task automatic test_error();
    bit to;
    clear_logs(); bp = 0; err_beat = 3;
    kick(64'h2000, 64'hA000, 64'd256);
    wait_done(to);
    n_total++; if (to) $display("FAIL error_timeout: got no done want done"); else n_pass++;
    n_total++; if (err !== 1'b1) $display("FAIL error_flag: got %b want 1", err); else n_pass++;
    n_total++; if (ar_cnt !== 1 || aw_cnt !== 1 || w_cnt !== 16)
      $display("FAIL error_counts: got ar=%0d aw=%0d w=%0d want 1 1 16", ar_cnt, aw_cnt, w_cnt);
    else n_pass++;
    err_beat = 1000;
  endtask

  task automatic test_reset_backpressure();
    bit to;
    bit reached;
    clear_logs(); bp = 1;
    kick(64'h3000, 64'hB000, 64'd128);
    reached = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge aclk);
      if (w_cnt >= 3 && w_valid) begin reached = 1'b1; break; end
    end
    n_total++; if (!reached) $display("FAIL bp_reach_wdata: got not reached want reached"); else n_pass++;
    #1 areset = 1'b1;
    #1;
    n_total++; if ({ar_valid, aw_valid, w_valid, r_ready, b_ready} !== 5'b0)
      $display("FAIL bp_reset_valids: got %b want 00000", {ar_valid, aw_valid, w_valid, r_ready, b_ready});
    else n_pass++;
    n_total++; if (done !== 1'b1 || err !== 1'b0)
      $display("FAIL bp_reset_done: got done=%b err=%b want 1 0", done, err);
    else n_pass++;
    repeat (2) @(posedge aclk);
    @(negedge aclk); areset = 1'b0;
    repeat (2) @(posedge aclk);
    clear_logs();
    kick(64'h4000, 64'hC000, 64'd64);
    wait_done(to);
    n_total++; if (to) $display("FAIL bp_timeout: got no done want done"); else n_pass++;
    n_total++; if (count_bad(64'h4000, 64'hC000, 8) !== 0)
      $display("FAIL bp_data: got %0d bad beats want 0", count_bad(64'h4000, 64'hC000, 8));
    else n_pass++;
    n_total++; if (ar_cnt !== 1 || aw_cnt !== 1 || err !== 1'b0 || order_err !== 0 || proto_err !== 0)
      $display("FAIL bp_protocol: got ar=%0d aw=%0d err=%b order=%0d proto=%0d want 1 1 0 0 0",
               ar_cnt, aw_cnt, err, order_err, proto_err);
    else n_pass++;
    bp = 0;
  endtask

  initial begin
    areset = 1'b1; en = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0;
    test_reset();
    test_single();
    test_two_bursts();
    test_4k_boundary();
    test_zero_length();
    test_error();
    test_reset_backpressure();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
